// File: rtl/fpu_bcd_convert_param.sv
// fpu_bcd_convert_param: packed-BCD <-> binary converter for the FPU load/store path
module fpu_bcd_convert_param #(
  parameter int NUM_DIGITS = 18,
  parameter int BIN_WIDTH = 64,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      mode,
  input  logic [4*NUM_DIGITS+7:0]   bcd_in,
  input  logic [BIN_WIDTH-1:0]      bin_in,
  input  logic                      sign_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BIN_WIDTH-1:0]      bin_out,
  output logic [4*NUM_DIGITS+7:0]   bcd_out,
  output logic                      sign_out,
  output logic                      err_pad,
  output logic                      err_digit,
  output logic [4:0]                err_digit_idx,
  output logic                      err_ovf
);
  localparam int N = NUM_DIGITS;
  localparam int D = DIGITS_PER_CYCLE;
  localparam int K = N / D;
  localparam int DW = 4 * N;
  localparam int PW = DW + 8;
  localparam int AW = BIN_WIDTH + 4 * D;
  localparam int CW = $clog2(BIN_WIDTH + K) + 1;

  typedef enum logic [1:0] {IDLE, CONV_BCD, CONV_BIN, DONE} state_t;
  state_t state, state_d;

  logic [DW-1:0]        dig, bcd_acc, adj, dab_bcd;
  logic [BIN_WIDTH-1:0] bin_sh, acc;
  logic [CW-1:0]        cnt;
  logic [4:0]           base, bad_idx;
  logic [AW-1:0]        grp, p, fold;
  logic [3:0]           nib, d;
  logic                 ovf_r, bad, ovf0, dab_c, last, accept, pad_bad;

  assign in_ready = state == IDLE;
  assign accept   = in_ready && in_valid;
  assign pad_bad  = !mode && |bcd_in[PW-2:DW];
  assign last     = cnt == (state == CONV_BIN ? CW'(BIN_WIDTH - 1) : CW'(K - 1));

  // Top D nibbles of dig are the group being folded; p ends at 10^D for the acc scale
  always_comb begin
    grp = '0;
    p = AW'(1);
    bad = 1'b0;
    bad_idx = '0;
    nib = '0;
    for (int i = 0; i < D; i++) begin
      nib = dig[DW-4*D+4*i +: 4];
      grp = grp + AW'(nib) * p;
      p = p * AW'(10);
      if (nib > 4'd9) begin
        bad = 1'b1;
        bad_idx = base + 5'(i);
      end
    end
    fold = AW'(acc) * p + grp;
    ovf0 = |fold[AW-1:BIN_WIDTH];
  end

  always_comb begin
    adj = '0;
    d = '0;
    for (int j = 0; j < N; j++) begin
      d = bcd_acc[4*j +: 4];
      adj[4*j +: 4] = d > 4'd4 ? d + 4'd3 : d;
    end
    dab_c = adj[DW-1];
    dab_bcd = {adj[DW-2:0], bin_sh[BIN_WIDTH-1]};
  end

  always_comb begin
    state_d = state;
    if (flush) state_d = IDLE;
    else if (accept) state_d = mode ? CONV_BIN : (pad_bad ? DONE : CONV_BCD);
    else if (state == CONV_BCD && (bad || ovf0 || last)) state_d = DONE;
    else if (state == CONV_BIN && last) state_d = DONE;
    else if (state == DONE && out_ready) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      dig <= '0;
      bin_sh <= '0;
      bcd_acc <= '0;
      acc <= '0;
      cnt <= '0;
      base <= '0;
      ovf_r <= 1'b0;
      out_valid <= 1'b0;
      bin_out <= '0;
      bcd_out <= '0;
      sign_out <= 1'b0;
      err_pad <= 1'b0;
      err_digit <= 1'b0;
      err_digit_idx <= '0;
      err_ovf <= 1'b0;
    end else if (accept) begin
      dig <= bcd_in[DW-1:0];
      bin_sh <= bin_in;
      bcd_acc <= '0;
      acc <= '0;
      cnt <= '0;
      base <= 5'(N - D);
      ovf_r <= 1'b0;
      out_valid <= pad_bad;
      bin_out <= '0;
      bcd_out <= '0;
      sign_out <= mode ? sign_in : bcd_in[PW-1];
      err_pad <= pad_bad;
      err_digit <= 1'b0;
      err_digit_idx <= '0;
      err_ovf <= 1'b0;
    end else if (state == CONV_BCD) begin
      dig <= dig << (4 * D);
      acc <= fold[BIN_WIDTH-1:0];
      cnt <= cnt + 1'b1;
      base <= base - 5'(D);
      out_valid <= bad || ovf0 || last;
      err_digit <= bad;
      err_digit_idx <= bad_idx;
      err_ovf <= !bad && ovf0;
      if (last && !bad && !ovf0) bin_out <= fold[BIN_WIDTH-1:0];
    end else if (state == CONV_BIN) begin
      bcd_acc <= dab_bcd;
      bin_sh <= bin_sh << 1;
      cnt <= cnt + 1'b1;
      ovf_r <= ovf_r || dab_c;
      if (last) begin
        out_valid <= 1'b1;
        err_ovf <= ovf_r || dab_c;
        bcd_out <= (ovf_r || dab_c) ? '0 : {sign_out, 7'd0, dab_bcd};
      end
    end else if (state == DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fpu_bcd_convert_param.sv
// tb_fpu_bcd_convert_param: directed vector bench for the BCD/binary converter
module tb_fpu_bcd_convert_param;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0;
  logic in_valid = 1'b0, in_valid3 = 1'b0, mode = 1'b0, sign_in = 1'b0;
  logic out_ready = 1'b0, out_ready3 = 1'b0;
  logic [79:0] bcd_in = '0;
  logic [63:0] bin_in = '0;
  logic in_ready, out_valid, sign_out, err_pad, err_digit, err_ovf;
  logic [63:0] bin_out;
  logic [79:0] bcd_out;
  logic [4:0] err_idx;
  logic in_ready3, out_valid3, sign_out3, err_pad3, err_digit3, err_ovf3;
  logic [63:0] bin_out3;
  logic [79:0] bcd_out3;
  logic [4:0] err_idx3;
  logic s_in_valid = 1'b0, s_mode = 1'b0, s_sign_in = 1'b0, s_out_ready = 1'b0;
  logic [23:0] s_bcd_in = '0;
  logic [11:0] s_bin_in = '0;
  logic s_in_ready, s_out_valid, s_sign_out, s_err_pad, s_err_digit, s_err_ovf;
  logic [11:0] s_bin_out;
  logic [23:0] s_bcd_out;
  logic [4:0] s_err_idx;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  fpu_bcd_convert_param dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .bcd_in(bcd_in), .bin_in(bin_in), .sign_in(sign_in), .out_valid(out_valid),
    .out_ready(out_ready), .bin_out(bin_out), .bcd_out(bcd_out), .sign_out(sign_out),
    .err_pad(err_pad), .err_digit(err_digit), .err_digit_idx(err_idx), .err_ovf(err_ovf));

  fpu_bcd_convert_param #(.DIGITS_PER_CYCLE(3)) dut3 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode), .bcd_in(bcd_in), .bin_in(bin_in), .sign_in(sign_in), .out_valid(out_valid3),
    .out_ready(out_ready3), .bin_out(bin_out3), .bcd_out(bcd_out3), .sign_out(sign_out3),
    .err_pad(err_pad3), .err_digit(err_digit3), .err_digit_idx(err_idx3), .err_ovf(err_ovf3));

  fpu_bcd_convert_param #(.NUM_DIGITS(4), .BIN_WIDTH(12)) dut_s (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .mode(s_mode), .bcd_in(s_bcd_in), .bin_in(s_bin_in), .sign_in(s_sign_in),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .bin_out(s_bin_out), .bcd_out(s_bcd_out),
    .sign_out(s_sign_out), .err_pad(s_err_pad), .err_digit(s_err_digit),
    .err_digit_idx(s_err_idx), .err_ovf(s_err_ovf));

  typedef struct {
    logic m; logic [79:0] bcd; logic [63:0] bin; logic sgn;
    logic [63:0] eb; logic [79:0] ebcd; logic es, ep, ed; logic [4:0] ei; logic eo; int lat;
  } vec_t;
  vec_t v[10];

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // w selects the DUT: 0 default, 1 three digits per cycle, 2 small
  task automatic go(input int w, output int lat);
    @(negedge clk);
    if (w == 0) in_valid = 1'b1;
    else if (w == 1) in_valid3 = 1'b1;
    else s_in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      in_valid = 1'b0; in_valid3 = 1'b0; s_in_valid = 1'b0;
    end while (!(w == 0 ? out_valid : w == 1 ? out_valid3 : s_out_valid) && lat < 200);
  endtask

  task automatic ack(input int w);
    @(negedge clk);
    if (w == 0) out_ready = 1'b1;
    else if (w == 1) out_ready3 = 1'b1;
    else s_out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; out_ready3 = 1'b0; s_out_ready = 1'b0;
  endtask

  initial begin
    int lat, seen;
    logic [63:0] held;
    v[0] = '{1'b0, 80'h80_123456789012345678, 64'h0, 1'b0, 64'h01B69B4BA630F34E, 80'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 19};
    v[1] = '{1'b0, 80'h00_999999999999999999, 64'h0, 1'b0, 64'h0DE0B6B3A763FFFF, 80'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 19};
    v[2] = '{1'b0, 80'h00_999999999999A99999, 64'h0, 1'b0, 64'h0, 80'h0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 14};
    v[3] = '{1'b0, 80'h01_000000000000000000, 64'h0, 1'b0, 64'h0, 80'h0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1};
    v[4] = '{1'b1, 80'h0, 64'h0DE0B6B3A763FFFF, 1'b1, 64'h0, 80'h80_999999999999999999, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 65};
    v[5] = '{1'b1, 80'h0, 64'h0DE0B6B3A7640000, 1'b0, 64'h0, 80'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 65};
    v[6] = '{1'b0, 80'h80_000000000000000000, 64'h0, 1'b0, 64'h0, 80'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 19};
    v[7] = '{1'b1, 80'h0, 64'd1234, 1'b0, 64'h0, 80'h00_000000000000001234, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 65};
    v[8] = '{1'b0, 80'h00_111111111111C1B1A1, 64'h0, 1'b0, 64'h0, 80'h0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 14};
    v[9] = '{1'b1, 80'h0, 64'h0, 1'b1, 64'h0, 80'h80_000000000000000000, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 65};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst in_ready", 80'(in_ready), 80'd1);
    chk("rst out_valid", 80'(out_valid), 80'd0);
    chk("rst bin_out", 80'(bin_out), 80'd0);
    chk("rst bcd_out", bcd_out, 80'd0);
    chk("rst in_ready3", 80'(in_ready3), 80'd1);
    chk("rst s_in_ready", 80'(s_in_ready), 80'd1);

    foreach (v[i]) begin
      mode = v[i].m; bcd_in = v[i].bcd; bin_in = v[i].bin; sign_in = v[i].sgn;
      go(0, lat);
      chk($sformatf("v%0d lat", i), 80'(lat), 80'(v[i].lat));
      chk($sformatf("v%0d bin_out", i), 80'(bin_out), 80'(v[i].eb));
      chk($sformatf("v%0d bcd_out", i), bcd_out, v[i].ebcd);
      chk($sformatf("v%0d sign_out", i), 80'(sign_out), 80'(v[i].es));
      chk($sformatf("v%0d err_pad", i), 80'(err_pad), 80'(v[i].ep));
      chk($sformatf("v%0d err_digit", i), 80'(err_digit), 80'(v[i].ed));
      chk($sformatf("v%0d err_idx", i), 80'(err_idx), 80'(v[i].ei));
      chk($sformatf("v%0d err_ovf", i), 80'(err_ovf), 80'(v[i].eo));
      ack(0);
    end

    foreach (v[i]) if (i == 0 || i == 1 || i == 8) begin
      mode = v[i].m; bcd_in = v[i].bcd; bin_in = v[i].bin; sign_in = v[i].sgn;
      go(1, lat);
      chk($sformatf("d3 v%0d lat", i), 80'(lat), i == 8 ? 80'd6 : 80'd7);
      chk($sformatf("d3 v%0d bin_out", i), 80'(bin_out3), 80'(v[i].eb));
      chk($sformatf("d3 v%0d sign_out", i), 80'(sign_out3), 80'(v[i].es));
      chk($sformatf("d3 v%0d err_digit", i), 80'(err_digit3), 80'(v[i].ed));
      chk($sformatf("d3 v%0d err_idx", i), 80'(err_idx3), 80'(v[i].ei));
      ack(1);
    end

    s_mode = 1'b0; s_bcd_in = 24'h00_4095;
    go(2, lat);
    chk("s 4095 lat", 80'(lat), 80'd5);
    chk("s 4095 bin_out", 80'(s_bin_out), 80'hFFF);
    chk("s 4095 err_ovf", 80'(s_err_ovf), 80'd0);
    ack(2);
    s_bcd_in = 24'h00_4096;
    go(2, lat);
    chk("s 4096 err_ovf", 80'(s_err_ovf), 80'd1);
    chk("s 4096 bin_out", 80'(s_bin_out), 80'd0);
    ack(2);
    s_mode = 1'b1; s_bin_in = 12'hFFF;
    go(2, lat);
    chk("s bin lat", 80'(lat), 80'd13);
    chk("s bin bcd_out", 80'(s_bcd_out), 80'h00_4095);
    chk("s bin err_ovf", 80'(s_err_ovf), 80'd0);
    ack(2);

    mode = v[1].m; bcd_in = v[1].bcd; bin_in = v[1].bin; sign_in = v[1].sgn;
    go(0, lat);
    held = bin_out;
    chk("bp first", 80'(held), 80'(v[1].eb));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1; bcd_in = v[0].bcd;
      @(posedge clk); #1;
      chk("bp out_valid", 80'(out_valid), 80'd1);
      chk("bp in_ready", 80'(in_ready), 80'd0);
      chk("bp bin_out", 80'(bin_out), 80'(v[1].eb));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp hs out_valid", 80'(out_valid), 80'd0);
    chk("bp hs in_ready", 80'(in_ready), 80'd1);

    mode = v[0].m; bcd_in = v[0].bcd; sign_in = 1'b0;
    @(negedge clk); in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    chk("flush in_ready", 80'(in_ready), 80'd1);
    chk("flush out_valid", 80'(out_valid), 80'd0);
    @(negedge clk); flush = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("flush no result", 80'(seen), 80'd0);
    bcd_in = v[1].bcd;
    go(0, lat);
    chk("post flush lat", 80'(lat), 80'd19);
    chk("post flush bin_out", 80'(bin_out), 80'(v[1].eb));
    ack(0);

    mode = v[4].m; bin_in = v[4].bin; sign_in = v[4].sgn; bcd_in = '0;
    @(negedge clk); in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rst mid out_valid", 80'(out_valid), 80'd0);
    chk("rst mid sign_out", 80'(sign_out), 80'd0);
    chk("rst mid bcd_out", bcd_out, 80'd0);
    chk("rst mid in_ready", 80'(in_ready), 80'd1);
    @(negedge clk); reset = 1'b0;
    go(0, lat);
    chk("post rst lat", 80'(lat), 80'd65);
    chk("post rst bcd_out", bcd_out, v[4].ebcd);
    ack(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
